int_to_float754: RTL
====================

Name: int_to_float754

Overview:
- Sequential converter from a 32-bit integer to an IEEE-754 single-precision word.
- Sits in front of the FloatingPointArithmetic unit and produces its input_a/input_b operands from integer sources. It is the encode side of the float format that the arithmetic unit consumes.
- Uses iterative normalization (one bit per cycle), round-to-nearest-even, and a valid/busy handshake.

Parameters:
SIGNED, 1, 1 = input is two's complement; 0 = input is unsigned (output sign bit always 0).

Ports:
clk  input  1  system clock (50 MHz), all logic on rising edge
rst  input  1  synchronous reset, active-high
input_valid  input  1  request strobe; sampled only in IDLE
input_int  input  32  integer operand, captured with input_valid
output_z  output  32  IEEE-754 single result; holds last result until the next one
output_valid  output  1  one-cycle pulse, output_z valid in the same cycle
busy  output  1  high while a conversion is in progress

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
  - rst asserted at an edge: state=IDLE, output_z=0, output_valid=0, busy=0, internal registers cleared.
  - Applies mid-conversion as well; an aborted conversion never produces output_valid.
- States: IDLE, NORM, ROUND.
- IDLE, on input_valid=1:
  - sign = SIGNED ? input_int[31] : 0.
  - mag = sign ? -input_int : input_int, as a 32-bit unsigned value. 0x80000000 gives mag 0x80000000.
  - exp = 158 (127+31).
  - If input_int==0: output_z=0x00000000 and output_valid=1 at that same edge; stay in IDLE. Latency 1. Negative zero is never produced.
  - Otherwise: go to NORM, busy=1.
- NORM, each edge:
  - If mag[31]=1: go to ROUND.
  - Else: mag = mag<<1 and exp = exp-1.
  - Number of shift cycles = lz, the leading-zero count of mag (0..31).
- ROUND, one edge:
  - Fields: mant = mag[30:8], G = mag[7], R = mag[6], S = |mag[5:0].
  - Round up if G & (R | S | mant[0]).
  - If the increment carries out of 23 bits: mant=0 and exp=exp+1.
  - output_z = {sign, exp[7:0], mant}; output_valid=1; busy=0; go to IDLE.
- Latency for a nonzero input: output_valid is high in the cycle after edge number lz+2, counting the capture edge as edge 0.
- Throughput: a new input_valid is accepted in the cycle output_valid is high.
- input_valid while busy=1 is ignored and dropped, with no queuing. The upstream must wait for busy=0.
- output_valid is high for exactly one cycle per accepted request; it is 0 in all other cycles.
- Overflow, NaN, infinities and denormals cannot occur: the maximum exponent after rounding is 158.
- No exceptions are flagged.
- Width rules:
  - exp is a 9-bit internal register; only [7:0] is emitted.
  - mag is a 32-bit unsigned internal register.

Test Plan:
1. rst=1 for 5 cycles with input_valid=1 -> output_z=0, output_valid=0, busy=0 throughout. Deassert rst, hold input_valid=1, input_int=0 -> output_valid pulses every cycle with output_z=0x00000000.
2. input_int=520 (0x00000208), SIGNED=1 -> output_z=0x44020000, output_valid high after capture edge+24 (lz=22), busy high for the intervening cycles. Then input_int=-13 -> 0xC1500000 after 30 edges (lz=28).
3. Boundary magnitudes:
   - input_int=0x80000000 (SIGNED=1) -> 0xCF000000, latency 2 (lz=0).
   - Same input with SIGNED=0 -> 0x4F000000.
   - input_int=0x00000001 -> 0x3F800000, latency 33.
4. Rounding:
   - 0x7FFFFFFF -> 0x4F000000 (mantissa carry into exponent).
   - 0x01000001 -> 0x4B800000 (tie, round to even).
   - 0x01000003 -> 0x4B800002 (tie, round up).
   - 0x00FFFFFF -> 0x4B7FFFFF (exact).
5. Handshake and reset:
   - Start 0x00000208; 5 cycles later pulse input_valid with 0x0000000D -> only 0x44020000 is produced; the second request is dropped.
   - Start 0x00000001; assert rst at edge 10 -> no output_valid, outputs 0, busy=0. A new request afterward converts correctly.

Source files
------------

// File: rtl/int_to_float754.sv
// int_to_float754: converts a 32-bit integer (two's complement or unsigned)
// into an IEEE-754 single-precision word. Normalization shifts one bit per
// cycle, then a single rounding cycle applies round-to-nearest-even.
module int_to_float754 #(
  parameter bit SIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        input_valid,
  input  logic [31:0] input_int,
  output logic [31:0] output_z,
  output logic        output_valid,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2
  } state_t;

  state_t state;
  state_t next_state;

  logic        sign_q;
  logic [31:0] mag;
  logic [8:0]  exp_q;

  // Operand preparation at capture time: sign and absolute magnitude.
  // 0x80000000 negates to itself, which is the correct unsigned magnitude.
  logic        sign_in;
  logic [31:0] mag_in;
  logic        is_zero;

  assign sign_in = SIGNED ? input_int[31] : 1'b0;
  assign mag_in  = sign_in ? (~input_int + 32'd1) : input_int;
  assign is_zero = (input_int == 32'd0);

  // Rounding fields once the leading one has reached bit 31. The hidden
  // bit is mag[31]; mantissa, guard, round and sticky follow below it.
  logic [22:0] mant;
  logic        guard_bit;
  logic        round_bit;
  logic        sticky_bit;
  logic        round_up;
  logic [23:0] mant_sum;
  logic [7:0]  rounded_exp;

  assign mant        = mag[30:8];
  assign guard_bit   = mag[7];
  assign round_bit   = mag[6];
  assign sticky_bit  = |mag[5:0];
  assign round_up    = guard_bit & (round_bit | sticky_bit | mant[0]);
  assign mant_sum    = {1'b0, mant} + {23'd0, round_up};
  assign rounded_exp = exp_q[7:0] + {7'd0, mant_sum[23]};

  // State register with synchronous reset, so a reset aborts any conversion.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: zero inputs finish directly from IDLE.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (input_valid && !is_zero) begin
          next_state = NORM;
        end
      end
      NORM: begin
        if (mag[31]) begin
          next_state = ROUND;
        end
      end
      ROUND: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Output logic: busy covers the whole normalize-and-round sequence.
  always_comb begin
    busy = (state != IDLE);
  end

  // Datapath: capture, shift-normalize, round and publish the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      sign_q       <= 1'b0;
      mag          <= 32'd0;
      exp_q        <= 9'd0;
      output_z     <= 32'd0;
      output_valid <= 1'b0;
    end else begin
      output_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (input_valid) begin
            sign_q <= sign_in;
            mag    <= mag_in;
            exp_q  <= 9'd158;
            if (is_zero) begin
              output_z     <= 32'd0;
              output_valid <= 1'b1;
            end
          end
        end
        NORM: begin
          if (!mag[31]) begin
            mag   <= mag << 1;
            exp_q <= exp_q - 9'd1;
          end
        end
        ROUND: begin
          output_z     <= {sign_q, rounded_exp, mant_sum[22:0]};
          output_valid <= 1'b1;
        end
        default: begin
          output_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
